// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory-mapped I/O slice.
// Defines the load-mux select codes driven by the address decoder and the
// I/O addresses the decoder compares against.
package mem_io_pkg;

  typedef enum logic [1:0] {
    MUX_SEL_RAM  = 2'b00,
    MUX_SEL_IN0  = 2'b01,
    MUX_SEL_IN1  = 2'b10,
    MUX_SEL_RSVD = 2'b11
  } mux_sel_e;

  localparam logic [31:0] IO_OUT_ADDR = 32'h0000_7FF0;
  localparam logic [31:0] IO_IN0_ADDR = 32'h0000_7FF4;
  localparam logic [31:0] IO_IN1_ADDR = 32'h0000_7FF8;

endpackage

// File: rtl/io_sync_chg.sv
// Input-port synchronizer with change detection and a sticky change flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pin        : asynchronous user input
//   rd_clr     : the synchronized value is being read this cycle
//   sync       : last stage of the synchronizer chain
//   chg        : sticky flag, set when sync changes, cleared on read
module io_sync_chg #(
  parameter int unsigned IN_W        = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] pin,
  input  logic            rd_clr,
  output logic [IN_W-1:0] sync,
  output logic            chg
);

  logic [IN_W-1:0] chain_q [SYNC_STAGES];
  logic [IN_W-1:0] sync_prev_q;
  logic            changed;

  assign sync    = chain_q[SYNC_STAGES-1];
  assign changed = (sync != sync_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      sync_prev_q <= '0;
      chg         <= 1'b0;
    end else begin
      chain_q[0] <= pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      sync_prev_q <= sync;
      // A change landing in the same cycle as a read must not be lost.
      if (changed)     chg <= 1'b1;
      else if (rd_clr) chg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_io_port_unit.sv
// Memory-mapped I/O datapath behind the MIPS address decoder.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   out_en, mux_sel     : decoder strobes (output-port store, load source)
//   wdata, ram_rdata    : CPU store data, synchronous data-RAM read word
//   in_port0, in_port1  : asynchronous user inputs
//   out_ack, clr_ovf    : output-port consumer acknowledge, overflow clear
//   rd_data             : load data to the CPU (one cycle after mux_sel)
//   out_port, out_valid : registered output value and its pending flag
//   out_ovf             : sticky overwrite-before-ack flag
//   in0_chg, in1_chg    : sticky input-change flags
module mem_io_port_unit
  import mem_io_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IN_W        = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_en,
  input  logic [1:0]        mux_sel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [IN_W-1:0]   in_port0,
  input  logic [IN_W-1:0]   in_port1,
  input  logic              out_ack,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              out_ovf,
  output logic              in0_chg,
  output logic              in1_chg
);

  mux_sel_e        sel_q;
  logic [IN_W-1:0] sync0;
  logic [IN_W-1:0] sync1;
  logic            ovf_set;

  io_sync_chg #(.IN_W(IN_W), .SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin    (in_port0),
    .rd_clr (sel_q == MUX_SEL_IN0),
    .sync   (sync0),
    .chg    (in0_chg)
  );

  io_sync_chg #(.IN_W(IN_W), .SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin    (in_port1),
    .rd_clr (sel_q == MUX_SEL_IN1),
    .sync   (sync1),
    .chg    (in1_chg)
  );

  // Select is delayed one cycle to line up with the synchronous RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= MUX_SEL_RAM;
    else        sel_q <= mux_sel_e'(mux_sel);
  end

  always_comb begin
    rd_data = '0;
    unique case (sel_q)
      MUX_SEL_RAM:  rd_data = ram_rdata;
      MUX_SEL_IN0:  rd_data = DATA_W'(sync0);
      MUX_SEL_IN1:  rd_data = DATA_W'(sync1);
      MUX_SEL_RSVD: rd_data = '0;
    endcase
  end

  // A simultaneous ack consumes the old value, so only an un-acked
  // overwrite counts as an overflow.
  assign ovf_set = out_en && out_valid && !out_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_port  <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_en) begin
        out_port  <= wdata;
        out_valid <= 1'b1;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
      if (ovf_set)      out_ovf <= 1'b1;
      else if (clr_ovf) out_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_io_port_unit.sv
module tb_mem_io_port_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IN_W   = 10;
  localparam int unsigned S      = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              out_en;
  logic [1:0]        mux_sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [IN_W-1:0]   in_port0;
  logic [IN_W-1:0]   in_port1;
  logic              out_ack;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;
  logic              out_ovf;
  logic              in0_chg;
  logic              in1_chg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_io_port_unit #(.DATA_W(DATA_W), .IN_W(IN_W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_en    (out_en),
    .mux_sel   (mux_sel),
    .wdata     (wdata),
    .ram_rdata (ram_rdata),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_ack   (out_ack),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ovf   (out_ovf),
    .in0_chg   (in0_chg),
    .in1_chg   (in1_chg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    out_en = 0; mux_sel = 2'b00; wdata = '0; ram_rdata = '0;
    in_port0 = '0; in_port1 = '0; out_ack = 0; clr_ovf = 0;
  endtask

  // ---------------- behavioural reference model ----------------
  // Pins seen at each clock edge are kept in a history; the synchronized
  // value is simply the pin as it was S edges ago.
  logic [IN_W-1:0]   h0[$], h1[$];
  logic [IN_W-1:0]   m_prev0, m_prev1;
  logic              m_chg0, m_chg1;
  logic [1:0]        m_sel;
  logic [DATA_W-1:0] m_port;
  logic              m_valid, m_ovf;

  task automatic model_reset();
    h0.delete(); h1.delete();
    for (int i = 0; i < int'(S); i++) begin h0.push_back('0); h1.push_back('0); end
    m_prev0 = '0; m_prev1 = '0; m_chg0 = 0; m_chg1 = 0;
    m_sel = 2'b00; m_port = '0; m_valid = 0; m_ovf = 0;
  endtask

  function automatic logic [DATA_W-1:0] model_rd();
    case (m_sel)
      2'b00:   return ram_rdata;
      2'b01:   return {{(DATA_W-IN_W){1'b0}}, h0[$]};
      2'b10:   return {{(DATA_W-IN_W){1'b0}}, h1[$]};
      default: return '0;
    endcase
  endfunction

  task automatic model_edge();
    logic lost;
    m_chg0 = (h0[$] != m_prev0) || (m_chg0 && m_sel != 2'b01);
    m_chg1 = (h1[$] != m_prev1) || (m_chg1 && m_sel != 2'b10);
    m_prev0 = h0[$]; m_prev1 = h1[$];
    h0.push_front(in_port0); void'(h0.pop_back());
    h1.push_front(in_port1); void'(h1.pop_back());
    m_sel = mux_sel;
    lost = 0;
    if (out_en) begin
      lost = m_valid && !out_ack;
      m_port = wdata; m_valid = 1;
    end else if (out_ack) begin
      m_valid = 0;
    end
    if (lost) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ram;
    logic        en;
    logic [31:0] wd;
    logic        ack;
    logic        clr;
    logic [31:0] exp_rd;
    logic [31:0] exp_port;
    logic        exp_valid;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2'b00, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0};
    vecs[1]  = '{2'b11, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2]  = '{2'b00, 32'hAAAA5555, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0};
    vecs[3]  = '{2'b00, 32'h00001111, 1, 32'h12345678, 0, 0, 32'h00001111, 32'h12345678, 1, 0};
    vecs[4]  = '{2'b00, 32'h00002222, 0, 32'h0,        1, 0, 32'h00002222, 32'h12345678, 0, 0};
    vecs[5]  = '{2'b00, 32'h00003333, 0, 32'h0,        1, 0, 32'h00003333, 32'h12345678, 0, 0};
    vecs[6]  = '{2'b00, 32'h00004444, 1, 32'hFFFFFFFF, 0, 0, 32'h00004444, 32'hFFFFFFFF, 1, 0};
    vecs[7]  = '{2'b00, 32'h00005555, 1, 32'h000000B2, 0, 0, 32'h00005555, 32'h000000B2, 1, 1};
    vecs[8]  = '{2'b00, 32'h00006666, 0, 32'h0,        0, 1, 32'h00006666, 32'h000000B2, 1, 0};
    vecs[9]  = '{2'b00, 32'h00007777, 1, 32'h000000C3, 1, 0, 32'h00007777, 32'h000000C3, 1, 0};
    vecs[10] = '{2'b00, 32'h00008888, 1, 32'h000000D4, 0, 1, 32'h00008888, 32'h000000D4, 1, 1};
    vecs[11] = '{2'b00, 32'h00009999, 0, 32'h0,        0, 1, 32'h00009999, 32'h000000D4, 1, 0};
    vecs[12] = '{2'b00, 32'h0000AAAA, 0, 32'h0,        1, 0, 32'h0000AAAA, 32'h000000D4, 0, 0};
  end

  initial begin
    // ---- reset with inputs toggling ----
    idle_inputs();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      out_en = 1; out_ack = $urandom_range(0, 1); clr_ovf = $urandom_range(0, 1);
      mux_sel = 2'($urandom_range(0, 3)); wdata = $urandom; ram_rdata = $urandom;
      in_port0 = IN_W'($urandom); in_port1 = IN_W'($urandom);
      #1;
      chk("reset_rd", rd_data, ram_rdata);
      chk("reset_port", out_port, '0);
      chk("reset_flags", {28'd0, out_valid, out_ovf, in0_chg, in1_chg}, '0);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      mux_sel = vecs[i].sel; ram_rdata = vecs[i].ram; out_en = vecs[i].en;
      wdata = vecs[i].wd; out_ack = vecs[i].ack; clr_ovf = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_port", i), out_port, vecs[i].exp_port);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].exp_ovf});
    end
    idle_inputs();

    // ---- input sync latency and sticky change flag ----
    ram_rdata = 32'hCAFE0000;
    in_port0 = 10'h155; mux_sel = 2'b01;
    for (int k = 1; k <= int'(S); k++) begin
      @(posedge clk); #1;
      chk($sformatf("sync_lat_k%0d", k), rd_data, (k == int'(S)) ? 32'h155 : 32'h0);
    end
    mux_sel = 2'b00;
    @(posedge clk); #1;
    chk("chg_set", {31'd0, in0_chg}, 32'd1);
    @(posedge clk); #1;
    chk("chg_sticky", {31'd0, in0_chg}, 32'd1);
    chk("chg1_quiet", {31'd0, in1_chg}, 32'd0);
    mux_sel = 2'b01;
    @(posedge clk); #1;
    chk("chg_read_rd", rd_data, 32'h155);
    mux_sel = 2'b00;
    @(posedge clk); #1;
    chk("chg_read_clr", {31'd0, in0_chg}, 32'd0);
    // pin change landing while the port is being read: set wins
    mux_sel = 2'b01; in_port0 = 10'h2AA;
    for (int k = 1; k <= int'(S) + 1; k++) @(posedge clk);
    #1;
    chk("chg_set_wins", {31'd0, in0_chg}, 32'd1);
    chk("chg_set_wins_rd", rd_data, 32'h2AA);
    @(posedge clk); #1;
    chk("chg_clr_after", {31'd0, in0_chg}, 32'd0);
    mux_sel = 2'b00;

    // ---- asynchronous reset while a value is pending ----
    out_en = 1; wdata = 32'h55AA_33CC;
    @(posedge clk); #1;
    chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    out_en = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_port", out_port, 32'd0);
    chk("arst_rd", rd_data, ram_rdata);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    model_reset();

    // ---- randomized run against the reference model ----
    for (int n = 0; n < 400; n++) begin
      out_en  = ($urandom_range(0, 2) == 0);
      out_ack = $urandom_range(0, 1);
      clr_ovf = ($urandom_range(0, 7) == 0);
      mux_sel = 2'($urandom_range(0, 3));
      wdata = $urandom; ram_rdata = $urandom;
      if ($urandom_range(0, 5) == 0) in_port0 = IN_W'($urandom);
      if ($urandom_range(0, 5) == 0) in_port1 = IN_W'($urandom);
      #1;
      chk("rnd_rd", rd_data, model_rd());
      model_edge();
      @(posedge clk); #1;
      chk("rnd_port", out_port, m_port);
      chk("rnd_flags", {28'd0, out_valid, out_ovf, in0_chg, in1_chg},
          {28'd0, m_valid, m_ovf, m_chg0, m_chg1});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
